reset_shutdown_sequencer: RTL
=============================

Name: reset_shutdown_sequencer

Overview:
Controlled reset-assertion (shutdown) sequencer, the counterpart of the staged release sequencer. On a shutdown request it quiesces and resets three domains in reverse order (stage 2, then 1, then 0). Each stage gets a quiesce request/acknowledge handshake with timeout before its active-low reset asserts. Once the request clears, the domains are released again in forward order (0, 1, 2) with a fixed gap.

Parameters:
DELAY_ASSERT, 4, cycles held in ASSERT after a stage reset asserts, before the next stage is quiesced (min 1)
DELAY_REL, 8, cycles between successive stage releases, and before the first release (min 1)
QTIMEOUT, 64, max cycles to wait for quiesce_ack per stage; 0 = wait forever
CW, 16, counter width; must satisfy 2^CW > max(DELAY_ASSERT, DELAY_REL, QTIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
shutdown_req  in  1  level request: hold domains in reset (sampled each edge)
quiesce_ack  in  3  per-stage ack, bit i = stage i drained/idle
quiesce_req  out  3  per-stage quiesce request, registered, one-hot or zero
rst0_n  out  1  stage 0 reset, active-low, registered
rst1_n  out  1  stage 1 reset, active-low, registered
rst2_n  out  1  stage 2 reset, active-low, registered
held  out  1  1 = all three resets asserted, sequence idle in HELD
busy  out  1  1 in QUIESCE, ASSERT or RELEASE
timeout_stat  out  3  sticky, bit i = stage i ack timed out
abort_stat  out  1  sticky, release sequence aborted by shutdown_req

Behaviour:
- Reset values (rst=1 at an edge): state=HELD, all rst*_n=0, quiesce_req=0, held=1, busy=0, timeout_stat=0, abort_stat=0, cnt=0, idx=0.
- HELD: held=1.
  - shutdown_req=0 -> RELEASE, idx=0, cnt=0.
  - Consequently, after power-on reset the block releases the domains by itself.
- RELEASE: cnt increments each cycle.
  - At cnt==DELAY_REL-1: rst{idx}_n<=1, cnt<=0, idx++.
  - After stage 2 is released -> RUN.
  - Outcome: rst0_n rises DELAY_REL cycles after entering RELEASE; each later stage rises DELAY_REL cycles after the previous one.
- RELEASE with shutdown_req=1 sampled: all rst*_n<=0 next edge, abort_stat<=1, -> HELD. No quiesce handshake, since released stages have not left reset activity yet.
- RUN: all rst*_n=1, held=0.
  - shutdown_req=1 -> QUIESCE, idx=2, cnt=0, quiesce_req[2]<=1 on the same edge.
- QUIESCE(idx): quiesce_req[idx]=1.
  - quiesce_ack[idx]=1 sampled -> ASSERT: rst{idx}_n<=0, quiesce_req<=0, cnt<=0.
  - Else cnt++. If QTIMEOUT!=0 and cnt==QTIMEOUT-1: timeout_stat[idx]<=1, then take the same ASSERT transition.
  - Acks of other stages are ignored.
- ASSERT(idx): cnt++.
  - At cnt==DELAY_ASSERT-1: if idx==0 -> HELD; else idx--, QUIESCE, cnt<=0, quiesce_req[idx-1]<=1.
- Timing, immediate ack:
  - qreq[2] goes high 1 cycle after shutdown_req is sampled.
  - rst2_n goes low 1 cycle after the ack is sampled.
  - qreq[1] goes high DELAY_ASSERT cycles after rst2_n falls.
- shutdown_req deassert during QUIESCE/ASSERT is ignored. The shutdown runs to HELD, then RELEASE starts (no partial reversal).
- Reset asserts only ever in order 2->1->0; release only in order 0->1->2. Invariant: rst0_n=1 implies the previous release was in order, and at no time is rstK_n=1 while rstJ_n=0 for J<K.
- Counters never wrap: they saturate at their compare point, and the state changes on it.
- rst mid-operation at any state: next edge gives the reset values (all resets asserted, quiesce_req dropped, status cleared).
- Sticky status bits clear only on rst.

Decomposition:
- Package rst_seq_pkg holds:
  - enum seq_st_e {ST_HELD, ST_RELEASE, ST_RUN, ST_QUIESCE, ST_ASSERT} (3-bit logic);
  - localparam NUM_STAGES=3;
  - stage index type logic [1:0].
- Single module. An optional sub-module stage_timer (load/count/done compare, CW wide) is shared by all waits.

Test Plan:
1. Power-up: rst=1 for 3 cycles, shutdown_req=0 -> rst*_n=0 during reset; rst0_n rises 8 cycles after rst falls, rst1_n 8 later, rst2_n 8 later; then busy=0, held=0.
2. In RUN, quiesce_ack=quiesce_req delayed 1 cycle, shutdown_req=1 -> qreq=100, rst2_n falls, 4 cycles later qreq=010, then rst1_n, then rst0_n; held=1; timeout_stat=000.
3. quiesce_ack[1] stuck 0 -> quiesce_req[1] high exactly 64 cycles, then rst1_n falls; timeout_stat=010; stage 0 sequence continues normally.
4. shutdown_req asserted 10 cycles into RELEASE (rst0_n already 1) -> next edge all rst*_n=0, held=1, abort_stat=1.
5. rst pulsed while in QUIESCE idx=1 (rst2_n=0, rst1_n=1) -> next edge all rst*_n=0, quiesce_req=000, timeout_stat=000, state HELD.
6. 1-cycle shutdown_req pulse in RUN -> full 2->1->0 shutdown completes, then automatic 0->1->2 release returns to RUN.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state, stage index and helpers for the shutdown sequencer
package rst_seq_pkg;
  localparam int NUM_STAGES = 3;
  typedef enum logic [2:0] {ST_HELD, ST_RELEASE, ST_RUN, ST_QUIESCE, ST_ASSERT} seq_st_e;
  typedef logic [1:0] stage_idx_t;
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_idx_t i);
    return NUM_STAGES'(1) << i;
  endfunction
endpackage

// File: rtl/reset_shutdown_sequencer_stage_timer.sv
// stage_timer: saturating wait counter with compare, shared by every sequencer wait
module stage_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic [CW-1:0] i_limit,
  output logic          o_done
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || i_clr) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
  assign o_done = r_cnt == i_limit;
endmodule

// File: rtl/reset_shutdown_sequencer.sv
// reset_shutdown_sequencer: quiesce and reset stages 2->1->0, release again 0->1->2
module reset_shutdown_sequencer
  import rst_seq_pkg::*;
#(
  parameter int DELAY_ASSERT = 4,
  parameter int DELAY_REL    = 8,
  parameter int QTIMEOUT     = 64,
  parameter int CW           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shutdown_req,
  input  logic [2:0] quiesce_ack,
  output logic [2:0] quiesce_req,
  output logic       rst0_n,
  output logic       rst1_n,
  output logic       rst2_n,
  output logic       held,
  output logic       busy,
  output logic [2:0] timeout_stat,
  output logic       abort_stat
);
  seq_st_e    r_state, w_state_nxt;
  stage_idx_t r_idx, w_idx_nxt;
  logic [2:0] r_rst_n, w_rst_n_nxt, r_qreq, w_qreq_nxt, r_tmo, w_tmo_nxt;
  logic       r_abort, w_abort_nxt;
  logic       w_clr, w_done, w_ack, w_tmo_hit;
  logic [CW-1:0] w_limit;

  assign w_limit = r_state == ST_RELEASE ? CW'(DELAY_REL - 1) :
                   r_state == ST_ASSERT  ? CW'(DELAY_ASSERT - 1) : CW'(QTIMEOUT - 1);
  assign w_ack     = quiesce_ack[r_idx];
  assign w_tmo_hit = (QTIMEOUT != 0) && w_done;

  stage_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_limit(w_limit),
    .o_done (w_done)
  );

  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ST_HELD;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_qreq  <= '0;
      r_tmo   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_qreq  <= w_qreq_nxt;
      r_tmo   <= w_tmo_nxt;
      r_abort <= w_abort_nxt;
    end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rst_n_nxt = r_rst_n;
    w_qreq_nxt  = r_qreq;
    w_tmo_nxt   = r_tmo;
    w_abort_nxt = r_abort;
    w_clr       = 1'b0;
    case (r_state)
      ST_HELD: begin
        w_clr = 1'b1;
        if (!shutdown_req) begin
          w_state_nxt = ST_RELEASE;
          w_idx_nxt   = '0;
        end
      end
      ST_RELEASE:
        // released stages have not started real work yet, so abort skips the handshake
        if (shutdown_req) begin
          w_state_nxt = ST_HELD;
          w_rst_n_nxt = '0;
          w_abort_nxt = 1'b1;
          w_clr       = 1'b1;
        end else if (w_done) begin
          w_rst_n_nxt[r_idx] = 1'b1;
          w_clr       = 1'b1;
          w_idx_nxt   = r_idx == 2'd2 ? r_idx : r_idx + 2'd1;
          w_state_nxt = r_idx == 2'd2 ? ST_RUN : ST_RELEASE;
        end
      ST_RUN: begin
        w_clr = 1'b1;
        if (shutdown_req) begin
          w_state_nxt = ST_QUIESCE;
          w_idx_nxt   = 2'd2;
          w_qreq_nxt  = stage_onehot(2'd2);
        end
      end
      ST_QUIESCE:
        if (w_ack || w_tmo_hit) begin
          w_state_nxt        = ST_ASSERT;
          w_rst_n_nxt[r_idx] = 1'b0;
          w_qreq_nxt         = '0;
          w_tmo_nxt[r_idx]   = r_tmo[r_idx] | !w_ack;
          w_clr              = 1'b1;
        end
      ST_ASSERT:
        if (w_done) begin
          w_clr       = 1'b1;
          w_state_nxt = r_idx == 2'd0 ? ST_HELD : ST_QUIESCE;
          w_idx_nxt   = r_idx == 2'd0 ? r_idx : r_idx - 2'd1;
          w_qreq_nxt  = r_idx == 2'd0 ? 3'b000 : stage_onehot(r_idx - 2'd1);
        end
      default: begin
        w_state_nxt = ST_HELD;
        w_rst_n_nxt = '0;
        w_qreq_nxt  = '0;
        w_clr       = 1'b1;
      end
    endcase
  end

  always_comb begin
    held         = r_state == ST_HELD;
    busy         = r_state inside {ST_QUIESCE, ST_ASSERT, ST_RELEASE};
    quiesce_req  = r_qreq;
    rst0_n       = r_rst_n[0];
    rst1_n       = r_rst_n[1];
    rst2_n       = r_rst_n[2];
    timeout_stat = r_tmo;
    abort_stat   = r_abort;
  end
endmodule
